// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch-predictor update scheduler.
// Used by bp_update_fifo and bp_update_scheduler.
package bp_pkg;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } bp_update_t;

    localparam int BP_DEFAULT_DEPTH        = 4;
    localparam int BP_DEFAULT_STARVE_LIMIT = 8;
    localparam int BP_STARVE_W             = 8;

endpackage

// File: rtl/bp_update_fifo.sv
// Update buffer for resolved branches: DEPTH entries (power of two), head visible
// combinationally. Pushes are ignored when full and pops are ignored when empty.
module bp_update_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  bp_update_t             push_data,
    input  logic                   pop,
    output bp_update_t             head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    bp_update_t        mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr];
    end

    // Storage is not reset: a cleared count already hides stale entries.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer wrap relies on DEPTH being a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/bp_update_scheduler.sv
// Arbitrates the predictor's single PC port between fetch lookups and buffered
// resolution updates. Optional statistics counters: define BP_SCHED_STATS_EN.
//
// state  | meaning
// NORMAL | lookups have priority; buffered updates use idle cycles
// DRAIN  | every cycle writes the FIFO head until the buffer is empty
module bp_update_scheduler
    import bp_pkg::*;
#(
    parameter int DEPTH        = BP_DEFAULT_DEPTH,
    parameter int STARVE_LIMIT = BP_DEFAULT_STARVE_LIMIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lookup_req,
    input  logic [31:0]            lookup_pc,
    output logic                   lookup_grant,
    output logic                   lookup_take,
    input  logic                   upd_valid,
    input  logic [31:0]            upd_pc,
    input  logic                   upd_taken,
    output logic                   upd_ready,
    output logic [31:0]            bp_pc,
    output logic                   bp_write_en,
    output logic                   bp_branch_taken,
    input  logic                   bp_take_branch,
    output logic [$clog2(DEPTH):0] pending
`ifdef BP_SCHED_STATS_EN
    ,
    output logic [31:0]            stat_lookups,
    output logic [31:0]            stat_updates,
    output logic [31:0]            stat_stall_cycles
`endif
);

    localparam int                     CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]          DEPTH_C  = CW'(DEPTH);
    localparam logic [BP_STARVE_W-1:0] STARVE_C = BP_STARVE_W'(STARVE_LIMIT);

    sched_state_t           state_q;
    sched_state_t           state_d;
    logic [BP_STARVE_W-1:0] starve_q;
    logic [BP_STARVE_W-1:0] starve_d;

    bp_update_t    push_data;
    bp_update_t    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          push;
    logic          lookup_slot;
    logic          update_slot;

    always_comb begin
        push_data.pc    = upd_pc;
        push_data.taken = upd_taken;
        push            = upd_valid && !fifo_full;
    end

    bp_update_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (update_slot),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= NORMAL;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Port arbitration is gated by rst so no write can leak out of a reset cycle.
    always_comb begin
        lookup_slot = 1'b0;
        update_slot = 1'b0;
        if (!rst) begin
            lookup_slot = (state_q == NORMAL) && lookup_req;
            update_slot = !fifo_empty && ((state_q == DRAIN) || !lookup_req);
        end
        count_next = count + CW'(push) - CW'(update_slot);
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        unique case (state_q)
            NORMAL: begin
                if (lookup_slot && !fifo_empty) begin
                    starve_d = (starve_q == '1) ? starve_q : starve_q + 1'b1;
                end else begin
                    starve_d = '0;
                end
                if ((starve_d >= STARVE_C) || (count_next == DEPTH_C)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                starve_d = '0;
                if (count_next == '0) begin
                    state_d = NORMAL;
                end
            end
            default: begin
                state_d  = NORMAL;
                starve_d = '0;
            end
        endcase
    end

    always_comb begin
        lookup_grant    = lookup_slot;
        lookup_take     = lookup_slot && bp_take_branch;
        bp_write_en     = update_slot;
        bp_branch_taken = update_slot && head.taken;
        bp_pc           = 32'h0;
        if (lookup_slot) begin
            bp_pc = lookup_pc;
        end else if (update_slot) begin
            bp_pc = head.pc;
        end
        upd_ready = !fifo_full;
        pending   = count;
    end

`ifdef BP_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups      <= '0;
            stat_updates      <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (lookup_slot && (stat_lookups != '1)) begin
                stat_lookups <= stat_lookups + 32'd1;
            end
            if (update_slot && (stat_updates != '1)) begin
                stat_updates <= stat_updates + 32'd1;
            end
            if (lookup_req && !lookup_grant && (stat_stall_cycles != '1)) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Self-checking bench for bp_update_scheduler: directed scenarios followed by
// randomized phases, all compared against a queue-based reference model.
module tb_bp_update_scheduler;
    import bp_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_req;
    logic [31:0] lookup_pc;
    logic        lookup_grant;
    logic        lookup_take;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_ready;
    logic [31:0] bp_pc;
    logic        bp_write_en;
    logic        bp_branch_taken;
    logic        bp_take_branch;
    logic [2:0]  pending;
`ifdef BP_SCHED_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_updates;
    logic [31:0] stat_stall_cycles;
`endif

    bp_update_scheduler #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .lookup_req      (lookup_req),
        .lookup_pc       (lookup_pc),
        .lookup_grant    (lookup_grant),
        .lookup_take     (lookup_take),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_ready       (upd_ready),
        .bp_pc           (bp_pc),
        .bp_write_en     (bp_write_en),
        .bp_branch_taken (bp_branch_taken),
        .bp_take_branch  (bp_take_branch),
        .pending         (pending)
`ifdef BP_SCHED_STATS_EN
        ,
        .stat_lookups      (stat_lookups),
        .stat_updates      (stat_updates),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: buffered updates in arrival order, drain flag, starve count
    bp_update_t mq[$];
    bit         m_drain  = 0;
    int         m_starve = 0;
`ifdef BP_SCHED_STATS_EN
    longint     m_lookups = 0;
    longint     m_updates = 0;
    longint     m_stalls  = 0;
`endif

    logic        obs_grant, obs_take, obs_wen, obs_taken, obs_ready;
    logic [31:0] obs_pc;
    logic [2:0]  obs_pending;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic rq, input logic [31:0] lpc,
                        input logic v, input logic [31:0] upc, input logic tk,
                        input logic tb_take);
        int         n;
        bit         e_lk;
        bit         e_up;
        bp_update_t hd;
        bp_update_t e;
        logic [31:0] e_pc;
        @(negedge clk);
        rst = r; lookup_req = rq; lookup_pc = lpc;
        upd_valid = v; upd_pc = upc; upd_taken = tk; bp_take_branch = tb_take;
        #1;
        obs_grant = lookup_grant; obs_take = lookup_take; obs_wen = bp_write_en;
        obs_taken = bp_branch_taken; obs_ready = upd_ready; obs_pc = bp_pc;
        obs_pending = pending;

        n    = mq.size();
        hd   = (n > 0) ? mq[0] : '0;
        e_lk = !r && !m_drain && rq;
        e_up = !r && (n > 0) && (m_drain || !rq);
        e_pc = e_lk ? lpc : (e_up ? hd.pc : 32'h0);
        chk("lookup_grant", {31'b0, lookup_grant}, {31'b0, e_lk});
        chk("lookup_take", {31'b0, lookup_take}, {31'b0, e_lk && tb_take});
        chk("bp_write_en", {31'b0, bp_write_en}, {31'b0, e_up});
        chk("bp_pc", bp_pc, e_pc);
        chk("bp_branch_taken", {31'b0, bp_branch_taken}, {31'b0, e_up && hd.taken});
        if (!r) begin
            chk("upd_ready", {31'b0, upd_ready}, {31'b0, n < DEPTH});
            chk("pending", {29'b0, pending}, 32'(n));
        end
`ifdef BP_SCHED_STATS_EN
        chk("stat_lookups", stat_lookups, 32'(m_lookups));
        chk("stat_updates", stat_updates, 32'(m_updates));
        chk("stat_stalls", stat_stall_cycles, 32'(m_stalls));
`endif

        @(posedge clk);
        if (r) begin
            mq.delete();
            m_drain  = 0;
            m_starve = 0;
`ifdef BP_SCHED_STATS_EN
            m_lookups = 0; m_updates = 0; m_stalls = 0;
`endif
        end else begin
`ifdef BP_SCHED_STATS_EN
            if (e_lk) m_lookups++;
            if (e_up) m_updates++;
            if (rq && !e_lk) m_stalls++;
`endif
            if (e_up) void'(mq.pop_front());
            if (v && n < DEPTH) begin
                e.pc = upc; e.taken = tk;
                mq.push_back(e);
            end
            if (!m_drain) begin
                m_starve = (e_lk && n > 0) ? m_starve + 1 : 0;
                if (m_starve >= LIMIT || mq.size() == DEPTH) m_drain = 1;
            end else begin
                m_starve = 0;
                if (mq.size() == 0) m_drain = 0;
            end
        end
    endtask

    task automatic idle(input logic rq);
        step(1'b0, rq, 32'h0000_0100, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; lookup_req = 1'b0; lookup_pc = '0; upd_valid = 1'b0;
        upd_pc = '0; upd_taken = 1'b0; bp_take_branch = 1'b0;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(0);
        chk("rst_ready", {31'b0, obs_ready}, 1);
        chk("rst_pending", {29'b0, obs_pending}, 0);
        chk("rst_wen", {31'b0, obs_wen}, 0);

        // zero-cycle lookup
        step(0, 1, 32'h0000_0400, 0, 0, 0, 1);
        chk("t1_grant", {31'b0, obs_grant}, 1);
        chk("t1_take", {31'b0, obs_take}, 1);
        chk("t1_wen", {31'b0, obs_wen}, 0);
        chk("t1_pc", obs_pc, 32'h0000_0400);

        // single update written the cycle after acceptance
        step(0, 0, 0, 1, 32'h0000_0800, 1, 0);
        chk("t2_wen_push_cycle", {31'b0, obs_wen}, 0);
        idle(0);
        chk("t2_wen", {31'b0, obs_wen}, 1);
        chk("t2_pc", obs_pc, 32'h0000_0800);
        chk("t2_taken", {31'b0, obs_taken}, 1);
        chk("t2_pending1", {29'b0, obs_pending}, 1);
        idle(0);
        chk("t2_pending0", {29'b0, obs_pending}, 0);

        // starvation guard
        step(0, 1, 32'h0000_0500, 1, 32'h0000_0900, 0, 0);
        for (int i = 0; i < LIMIT; i++) begin
            idle(1);
            chk("t3_grant", {31'b0, obs_grant}, 1);
        end
        idle(1);
        chk("t3_drain_grant", {31'b0, obs_grant}, 0);
        chk("t3_drain_wen", {31'b0, obs_wen}, 1);
        chk("t3_drain_pc", obs_pc, 32'h0000_0900);
        idle(1);
        chk("t3_back_grant", {31'b0, obs_grant}, 1);

        // full FIFO forces drain in push order
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 32'h0000_0600, 1, 32'h0000_1000 + 32'(i), 1'(i & 1), 0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            idle(1);
            chk("t4_wen", {31'b0, obs_wen}, 1);
            chk("t4_pc", obs_pc, 32'h0000_1000 + 32'(i));
            if (i == 0) chk("t4_ready_full", {31'b0, obs_ready}, 0);
            if (i == 1) chk("t4_ready_after_pop", {31'b0, obs_ready}, 1);
        end
        idle(1);
        chk("t4_back_grant", {31'b0, obs_grant}, 1);

        // simultaneous push and pop
        step(0, 1, 0, 1, 32'h0000_2000, 0, 0);
        step(0, 1, 0, 1, 32'h0000_2001, 1, 0);
        step(0, 0, 0, 1, 32'h0000_2002, 0, 0);
        chk("t5_pending", {29'b0, obs_pending}, 2);
        chk("t5_pc0", obs_pc, 32'h0000_2000);
        idle(0);
        chk("t5_pending_kept", {29'b0, obs_pending}, 2);
        chk("t5_pc1", obs_pc, 32'h0000_2001);
        idle(0);
        chk("t5_pc2", obs_pc, 32'h0000_2002);
        idle(0);

        // reset with pending entries
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 32'h0000_3000 + 32'(i), 1, 0);
        step(1, 0, 0, 1, 32'h0000_3FFF, 1, 0);
        chk("t6_rst_wen", {31'b0, obs_wen}, 0);
        idle(0);
        chk("t6_pending", {29'b0, obs_pending}, 0);
        chk("t6_ready", {31'b0, obs_ready}, 1);
        chk("t6_wen", {31'b0, obs_wen}, 0);
        idle(0);
        chk("t6_no_stale", {31'b0, obs_wen}, 0);

        // randomized phases with varying request/offer densities
        for (int ph = 0; ph < 10; ph++) begin
            int preq;
            int pval;
            preq = (ph == 0) ? 100 : (ph == 1) ? 0 : $urandom_range(0, 100);
            pval = (ph == 2) ? 100 : $urandom_range(10, 100);
            for (int c = 0; c < 300; c++) begin
                step(1'($urandom_range(0, 249) == 0),
                     1'($urandom_range(0, 99) < preq), $urandom,
                     1'($urandom_range(0, 99) < pval), $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_update_scheduler.md
# bp_update_scheduler

Sequences all accesses to the global branch predictor, which has a single PC port shared by fetch-stage lookups (combinational read) and execute-stage resolution updates (synchronous write). Resolved outcomes are buffered in a small FIFO and written back in cycles fetch does not need the port. A starvation guard and full-FIFO drain mode keep the buffer bounded. Sits between IF/EX and the predictor instance.

## Interface
- DEPTH, 4: update FIFO entries; power of two, 2..16.
- STARVE_LIMIT, 8: consecutive cycles a non-empty FIFO may be denied before a forced drain; 1..255.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- lookup_req  in  1  fetch requests a prediction this cycle.
- lookup_pc  in  32  fetch PC.
- lookup_grant  out  1  lookup served this cycle; fetch stalls when req=1 and grant=0.
- lookup_take  out  1  prediction, valid when lookup_grant=1; else 0.
- upd_valid  in  1  resolved branch offered.
- upd_pc  in  32  branch PC.
- upd_taken  in  1  actual outcome.
- upd_ready  out  1  FIFO accepts; transfer on upd_valid & upd_ready.
- bp_pc  out  32  to predictor pc_value.
- bp_write_en  out  1  to predictor write_en.
- bp_branch_taken  out  1  to predictor branch_taken.
- bp_take_branch  in  1  from predictor take_branch.
- pending  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FSM states NORMAL, DRAIN; reset → NORMAL.
- NORMAL: lookup_req=1 → lookup slot (bp_pc=lookup_pc, bp_write_en=0, lookup_grant=1, lookup_take=bp_take_branch). Otherwise, FIFO non-empty → update slot. Otherwise idle (bp_pc=0, write_en=0).
- Update slot: bp_pc/bp_branch_taken = FIFO head, bp_write_en=1, head popped at clock edge. lookup_grant=0.
- Starve counter (8 b): increments each NORMAL cycle with FIFO non-empty and lookup slot taken; clears on any update slot or empty FIFO.
- NORMAL → DRAIN when, at a clock edge, the counter reaches STARVE_LIMIT or occupancy after push/pop equals DEPTH.
- DRAIN: update slot every cycle regardless of lookup_req; → NORMAL at the edge where occupancy becomes 0 (last pop, no concurrent push). Pushes during DRAIN extend it.
- upd_ready = (pending < DEPTH); no write-through when full, even with a pop the same cycle.
- Simultaneous push and pop: occupancy unchanged, order preserved (push lands behind head).
- Pointers wrap modulo DEPTH; occupancy never exceeds DEPTH or goes below 0.
- Same-PC updates apply strictly in arrival order; lookups see only committed state (no bypass of pending entries).

## Timing
- Reset values: lookup_grant=0, lookup_take=0, upd_ready=1, bp_pc=0, bp_write_en=0, bp_branch_taken=0, pending=0, starve=0, state NORMAL.
- Lookup: zero-cycle; grant/take combinational from lookup_req and state.
- Update: accepted at edge N, earliest predictor write at edge N+1 (entry becomes head in cycle after push).
- Reset mid-operation: FIFO contents discarded, no write issued in reset cycle (bp_write_en=0 while rst=1).
- Worst-case fetch stall: DEPTH cycles plus pushes arriving during DRAIN.

## Configuration
- BP_SCHED_STATS_EN defined: adds outputs stat_lookups, stat_updates, stat_stall_cycles (each 32 b, saturating at all-ones, cleared on rst); stall = lookup_req & ~lookup_grant.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package bp_pkg: sched_state_t enum (NORMAL, DRAIN), bp_update_t struct {pc[31:0], taken}, default DEPTH/STARVE_LIMIT constants.
- Sub-module bp_update_fifo (parameterised DEPTH, bp_update_t payload, push/pop/full/empty/count); arbitration, FSM and starve counter in the top.

## Test plan
- Reset then lookup_req=1, lookup_pc=0x0000_0400, bp_take_branch=1 → lookup_grant=1, lookup_take=1, bp_write_en=0, same cycle.
- Push one update (pc 0x0000_0800, taken 1) with lookup_req=0 → next cycle bp_write_en=1, bp_pc=0x800, bp_branch_taken=1; pending 1→0.
- lookup_req held 1, one update pushed → 8 granted lookups, then DRAIN: one cycle lookup_grant=0, bp_write_en=1, back to NORMAL.
- Push 4 updates back-to-back with lookup_req=1 → upd_ready=0 when pending=4, DRAIN 4 cycles with writes in push order, upd_ready=1 after first pop.
- Simultaneous push and pop at pending=2 → pending stays 2, write order matches push order.
- rst asserted with pending=3 → next cycle pending=0, bp_write_en=0, upd_ready=1, no stale writes afterwards.
